// File: rtl/jtag_host_driver.sv
// ---------------------------------------------------------------------------
// jtag_host_driver
//
// Host-side JTAG sequencer in the sys_clk domain. Converts command-level
// requests (TAP reset, IR scan, DR scan, idle clocking) into TCK/TMS/TDI
// waveforms and returns the TDO bits captured while shifting. Every operation
// starts and ends with the TAP in Run-Test/Idle.
//
// Optional feature: define JTAG_DRV_TRST_EN to add the active-low trst output.
//
// Ports:
//   sys_clk    system clock
//   dbg_rst    asynchronous active-low reset
//   cmd_valid  command request
//   cmd_ready  idle, command can be accepted
//   cmd_op     00 RESET, 01 IR scan, 10 DR scan, 11 IDLE clocks
//   cmd_len    scan length or idle TCK count (saturated to MAX_LEN)
//   cmd_data   TDI bits, shifted LSB first
//   rsp_valid  response available, held until rsp_ready
//   rsp_ready  response consumed
//   rsp_data   captured TDO, bit i = i-th shifted bit
//   tck/tms/tdi  JTAG outputs to the target TAP
//   tdo        JTAG data from the target
//   trst       active-low TAP reset (JTAG_DRV_TRST_EN only)
// ---------------------------------------------------------------------------
module jtag_host_driver #(
    parameter int TCK_DIV = 4,
    parameter int MAX_LEN = 32,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               sys_clk,
    input  logic               dbg_rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LW-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
`ifdef JTAG_DRV_TRST_EN
    ,
    output logic               trst
`endif
);

    localparam int DIVW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP} state_t;

    state_t state_r, state_nxt;

    // Lengths above MAX_LEN saturate to MAX_LEN.
    function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] len);
        if (len > LW'(MAX_LEN)) return LW'(MAX_LEN);
        return len;
    endfunction

    // Control registers (reset)
    logic [DIVW-1:0]    div_cnt_r;
    logic               tck_r, tms_r, tdi_r;
    logic [MAX_LEN-1:0] cap_r;

    // Per-command working registers, always loaded on accept
    logic [LW-1:0]      rem_r;        // TCKs left in the current phase, incl. current
    logic [MAX_LEN-1:0] data_sr;      // bit 0 = TDI bit of the current shift TCK
    logic [MAX_LEN-1:0] mask_r;       // one-hot position of the current capture bit
    logic [4:0]         pre_sr;       // bit 0 = TMS of the current preamble TCK
    logic [2:0]         post_sr;      // bit 0 = TMS of the current postamble TCK
    logic [1:0]         post_len_r;
    logic [LW-1:0]      shift_len_r;
    logic               scan_r;       // IR/DR op: drives TDI and captures TDO

    // Decoded incoming command
    logic               accept;
    logic [LW-1:0]      len_c;
    logic [4:0]         acc_pre_pat;
    logic [2:0]         acc_pre_len;
    logic [LW-1:0]      acc_shift_len;
    logic [2:0]         acc_post_pat;
    logic [1:0]         acc_post_len;
    logic               acc_scan;

    logic               in_op, div_end, period_end, last;
    logic               tms_nxt, tdi_nxt;

    always_comb begin
        accept        = cmd_valid && (state_r == S_IDLE);
        len_c         = sat_len(cmd_len);
        acc_pre_pat   = 5'b00000;
        acc_pre_len   = 3'd0;
        acc_shift_len = '0;
        acc_post_pat  = 3'b000;
        acc_post_len  = 2'd0;
        acc_scan      = 1'b0;
        // Patterns are listed LSB = first TCK. A zero-length scan leaves
        // Capture with TMS=1 and walks Exit1 -> Update -> Idle.
        case (cmd_op)
            OP_RESET: begin
                acc_pre_pat  = 5'b11111;
                acc_pre_len  = 3'd5;
                acc_post_pat = 3'b000;
                acc_post_len = 2'd1;
            end
            OP_IR: begin
                acc_scan      = 1'b1;
                acc_shift_len = len_c;
                acc_pre_pat   = 5'b00011;
                if (len_c != '0) begin
                    acc_pre_len  = 3'd4;
                    acc_post_pat = 3'b001;
                    acc_post_len = 2'd2;
                end else begin
                    acc_pre_len  = 3'd3;
                    acc_post_pat = 3'b011;
                    acc_post_len = 2'd3;
                end
            end
            OP_DR: begin
                acc_scan      = 1'b1;
                acc_shift_len = len_c;
                acc_pre_pat   = 5'b00001;
                if (len_c != '0) begin
                    acc_pre_len  = 3'd3;
                    acc_post_pat = 3'b001;
                    acc_post_len = 2'd2;
                end else begin
                    acc_pre_len  = 3'd2;
                    acc_post_pat = 3'b011;
                    acc_post_len = 2'd3;
                end
            end
            default: begin
                // Idle clocking runs through SHIFT with TMS=0 and no data.
                acc_shift_len = len_c;
            end
        endcase
    end

    always_comb begin
        in_op      = (state_r == S_PRE) || (state_r == S_SHIFT) || (state_r == S_POST);
        div_end    = (div_cnt_r == DIVW'(TCK_DIV - 1));
        period_end = in_op && tck_r && div_end;
        last       = (rem_r == LW'(1));

        state_nxt = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_IDLE) state_nxt = (len_c == '0) ? S_RESP : S_SHIFT;
                    else                   state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                if (period_end && last) state_nxt = (shift_len_r != '0) ? S_SHIFT : S_POST;
            end
            S_SHIFT: begin
                if (period_end && last) state_nxt = scan_r ? S_POST : S_RESP;
            end
            S_POST: begin
                if (period_end && last) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // TMS/TDI for the next TCK period, loaded as its low phase begins.
        tms_nxt = tms_r;
        tdi_nxt = tdi_r;
        if (accept) begin
            tms_nxt = (state_nxt == S_PRE) ? acc_pre_pat[0] : 1'b0;
            tdi_nxt = 1'b0;
        end else if (period_end) begin
            tdi_nxt = 1'b0;
            if (!last) begin
                case (state_r)
                    S_PRE:   tms_nxt = pre_sr[1];
                    S_SHIFT: begin
                        tms_nxt = scan_r && (rem_r == LW'(2));
                        tdi_nxt = scan_r && data_sr[1];
                    end
                    default: tms_nxt = post_sr[1];
                endcase
            end else begin
                case (state_nxt)
                    S_SHIFT: begin
                        tms_nxt = scan_r && (shift_len_r == LW'(1));
                        tdi_nxt = scan_r && data_sr[0];
                    end
                    S_POST:  tms_nxt = post_sr[0];
                    default: tms_nxt = tms_r;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) begin
            state_r   <= S_IDLE;
            div_cnt_r <= '0;
            tck_r     <= 1'b0;
            tms_r     <= 1'b1;
            tdi_r     <= 1'b0;
            cap_r     <= '0;
        end else begin
            state_r <= state_nxt;
            tms_r   <= tms_nxt;
            tdi_r   <= tdi_nxt;
            if (in_op) begin
                if (div_end) begin
                    div_cnt_r <= '0;
                    tck_r     <= ~tck_r;
                end else begin
                    div_cnt_r <= div_cnt_r + DIVW'(1);
                end
            end else begin
                div_cnt_r <= '0;
                tck_r     <= 1'b0;
            end
            // TDO is taken on the last sys_clk of the high phase.
            if (accept)
                cap_r <= '0;
            else if (period_end && (state_r == S_SHIFT) && scan_r && tdo)
                cap_r <= cap_r | mask_r;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            data_sr     <= cmd_data;
            mask_r      <= MAX_LEN'(1);
            pre_sr      <= acc_pre_pat;
            post_sr     <= acc_post_pat;
            post_len_r  <= acc_post_len;
            shift_len_r <= acc_shift_len;
            scan_r      <= acc_scan;
            rem_r       <= (cmd_op == OP_IDLE) ? len_c : LW'(acc_pre_len);
        end else if (period_end) begin
            if (state_r == S_SHIFT) mask_r <= mask_r << 1;
            if (!last) begin
                rem_r <= rem_r - LW'(1);
                case (state_r)
                    S_PRE:   pre_sr  <= pre_sr >> 1;
                    S_SHIFT: data_sr <= data_sr >> 1;
                    default: post_sr <= post_sr >> 1;
                endcase
            end else begin
                if (state_nxt == S_SHIFT) rem_r <= shift_len_r;
                else                      rem_r <= LW'(post_len_r);
            end
        end
    end

`ifdef JTAG_DRV_TRST_EN
    // trst is held low only while a RESET op walks its TMS=1 preamble.
    logic rst_op_r;
    logic rst_op_nxt;
    logic trst_r;

    always_comb begin
        rst_op_nxt = accept ? (cmd_op == OP_RESET) : rst_op_r;
    end

    always_ff @(posedge sys_clk) begin
        if (accept) rst_op_r <= (cmd_op == OP_RESET);
    end

    always_ff @(posedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) trst_r <= 1'b0;
        else          trst_r <= !((state_nxt == S_PRE) && rst_op_nxt);
    end

    assign trst = trst_r;
`endif

    assign cmd_ready = (state_r == S_IDLE);
    assign rsp_valid = (state_r == S_RESP);
    assign rsp_data  = cap_r;
    assign tck       = tck_r;
    assign tms       = tms_r;
    assign tdi       = tdi_r;

endmodule

// File: tb/tb_jtag_host_driver.sv
// ---------------------------------------------------------------------------
// tb_jtag_host_driver
//
// Directed bench for jtag_host_driver with TCK_DIV=2 and TDO looped back to
// TDI. Covers reset values, RESET/IR/DR/IDLE ops, zero-length scans, length
// saturation, response back-pressure and a reset in the middle of a DR shift.
// ---------------------------------------------------------------------------
module tb_jtag_host_driver;

    localparam int TCK_DIV = 2;
    localparam int MAX_LEN = 32;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int PER     = 2 * TCK_DIV;

    logic               sys_clk = 1'b0;
    logic               dbg_rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LW-1:0]      cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tck, tms, tdi, tdo;
`ifdef JTAG_DRV_TRST_EN
    logic               trst;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    jtag_host_driver #(.TCK_DIV(TCK_DIV), .MAX_LEN(MAX_LEN), .LW(LW)) dut (
        .sys_clk   (sys_clk),
        .dbg_rst   (dbg_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
`ifdef JTAG_DRV_TRST_EN
        ,
        .trst      (trst)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    assign tdo = tdi;

    // TCK-edge recorder: newest bit lands in bit 0.
    int          tck_cnt   = 0;
    logic [63:0] tms_hist  = '0;
    logic [63:0] tdi_hist  = '0;
    logic [63:0] trst_hist = '0;

    always @(posedge tck) begin
        tck_cnt  <= tck_cnt + 1;
        tms_hist <= {tms_hist[62:0], tms};
        tdi_hist <= {tdi_hist[62:0], tdi};
`ifdef JTAG_DRV_TRST_EN
        trst_hist <= {trst_hist[62:0], trst};
`endif
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] low_bits(input logic [63:0] v, input int n);
        logic [63:0] m;
        m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        return v & m;
    endfunction

    // Issue one command and wait for its response; lat = 1 means rsp_valid in
    // the cycle right after the accept cycle.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [LW-1:0] len,
                          input logic [MAX_LEN-1:0] data, output int lat, output int pulses);
        int c0;
        logic got;
        c0 = tck_cnt;
        @(negedge sys_clk);
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        chk({tag, "_ready"}, cmd_ready, 1'b1);
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 2000) begin
            lat++;
            if (rsp_valid) got = 1'b1;
            else begin
                @(posedge sys_clk);
                #1;
            end
        end
        chk({tag, "_rsp_seen"}, got, 1'b1);
        pulses = tck_cnt - c0;
    endtask

    task automatic take_rsp(input string tag);
        @(negedge sys_clk);
        rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1 rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, rsp_valid, 1'b0);
    endtask

    initial begin
        int lat, pulses, c0, guard, bad_cycles;
        dbg_rst   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_tck", tck, 1'b0);
        chk("rst_tms", tms, 1'b1);
        chk("rst_tdi", tdi, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
`ifdef JTAG_DRV_TRST_EN
        chk("rst_trst", trst, 1'b0);
`endif
        @(negedge sys_clk);
        dbg_rst = 1'b1;
`ifdef JTAG_DRV_TRST_EN
        @(posedge sys_clk);
        #1 chk("trst_release", trst, 1'b1);
`endif

        // RESET op: 6 TCKs, TMS 1,1,1,1,1,0, response 6*4+1 cycles after accept
        do_cmd("reset", 2'b00, LW'(0), 32'h0, lat, pulses);
        chk("reset_lat", lat, 25);
        chk("reset_pulses", pulses, 6);
        chk("reset_tms", low_bits(tms_hist, 6), 6'b111110);
        chk("reset_data", rsp_data, 32'h0);
`ifdef JTAG_DRV_TRST_EN
        chk("reset_trst", low_bits(trst_hist, 6), 6'b000001);
`endif
        take_rsp("reset");

        // IR scan, 4 bits of 0001
        do_cmd("ir4", 2'b01, LW'(4), 32'h1, lat, pulses);
        chk("ir4_lat", lat, 10 * PER + 1);
        chk("ir4_pulses", pulses, 10);
        chk("ir4_tms", low_bits(tms_hist, 10), 10'b1100000110);
        chk("ir4_tdi", low_bits(tdi_hist, 10), 10'b0000100000);
        chk("ir4_data", rsp_data, 32'h1);
        take_rsp("ir4");

        // DR scan, 32 bits
        do_cmd("dr32", 2'b10, LW'(32), 32'hDEADBEEF, lat, pulses);
        chk("dr32_pulses", pulses, 37);
        chk("dr32_lat", lat, 37 * PER + 1);
        chk("dr32_data", rsp_data, 32'hDEADBEEF);
        chk("dr32_tms", low_bits(tms_hist, 37), {3'b100, 32'h0000_0001, 2'b10});
        take_rsp("dr32");

        // Zero-length DR scan
        do_cmd("dr0", 2'b10, LW'(0), 32'hFFFF_FFFF, lat, pulses);
        chk("dr0_pulses", pulses, 5);
        chk("dr0_tms", low_bits(tms_hist, 5), 5'b10110);
        chk("dr0_data", rsp_data, 32'h0);
        chk("dr0_lat", lat, 5 * PER + 1);
        take_rsp("dr0");

        // Zero-length IR scan
        do_cmd("ir0", 2'b01, LW'(0), 32'hFFFF_FFFF, lat, pulses);
        chk("ir0_pulses", pulses, 6);
        chk("ir0_tms", low_bits(tms_hist, 6), 6'b110110);
        chk("ir0_data", rsp_data, 32'h0);
        take_rsp("ir0");

        // IDLE with zero count: no TCK, response the cycle after accept
        do_cmd("idle0", 2'b11, LW'(0), 32'h0, lat, pulses);
        chk("idle0_lat", lat, 1);
        chk("idle0_pulses", pulses, 0);
        take_rsp("idle0");

        // IDLE with 3 TCKs, TMS held low, no captured data
        do_cmd("idle3", 2'b11, LW'(3), 32'hFFFF_FFFF, lat, pulses);
        chk("idle3_pulses", pulses, 3);
        chk("idle3_tms", low_bits(tms_hist, 3), 3'b000);
        chk("idle3_tdi", low_bits(tdi_hist, 3), 3'b000);
        chk("idle3_data", rsp_data, 32'h0);
        take_rsp("idle3");

        // Length above MAX_LEN saturates to 32
        do_cmd("clamp", 2'b10, LW'(40), 32'h1234_5678, lat, pulses);
        chk("clamp_pulses", pulses, 37);
        chk("clamp_data", rsp_data, 32'h1234_5678);
        take_rsp("clamp");

        // Back-pressure: response held while rsp_ready stays low
        do_cmd("hold", 2'b01, LW'(2), 32'hFFFF_FFFE, lat, pulses);
        chk("hold_data", rsp_data, 32'h2);
        c0 = tck_cnt;
        bad_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk);
            #1;
            if (!(rsp_valid === 1'b1 && rsp_data === 32'h2 && cmd_ready === 1'b0 && tck === 1'b0))
                bad_cycles++;
        end
        chk("hold_stable", bad_cycles, 0);
        chk("hold_no_tck", tck_cnt - c0, 0);
        take_rsp("hold");

        // Reset during bit 10 of a 32-bit DR shift (3 preamble TCKs first)
        c0 = tck_cnt;
        @(negedge sys_clk);
        cmd_op    = 2'b10;
        cmd_len   = LW'(32);
        cmd_data  = 32'hA5A5_A5A5;
        cmd_valid = 1'b1;
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        guard = 0;
        while ((tck_cnt - c0) < 14 && guard < 500) begin
            @(negedge sys_clk);
            guard++;
        end
        chk("abort_reached_bit10", (tck_cnt - c0), 14);
        dbg_rst = 1'b0;
        #1;
        chk("abort_tck", tck, 1'b0);
        chk("abort_tms", tms, 1'b1);
        chk("abort_tdi", tdi, 1'b0);
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        chk("abort_rsp_data", rsp_data, 32'h0);
        bad_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge sys_clk);
            #1;
            if (rsp_valid !== 1'b0) bad_cycles++;
        end
        @(negedge sys_clk);
        dbg_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge sys_clk);
            #1;
            if (rsp_valid !== 1'b0) bad_cycles++;
        end
        chk("abort_no_rsp", bad_cycles, 0);

        do_cmd("reset2", 2'b00, LW'(0), 32'h0, lat, pulses);
        chk("reset2_lat", lat, 25);
        chk("reset2_pulses", pulses, 6);
        chk("reset2_tms", low_bits(tms_hist, 6), 6'b111110);
        take_rsp("reset2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_host_driver.md
# jtag_host_driver

Host-side JTAG sequencer in the `sys_clk` domain. It turns command-level requests into TCK/TMS/TDI waveforms that drive the TAP of `jtag_test_logic`, and returns the TDO bits captured during the shift phase. It walks the TAP state machine from Run-Test/Idle for IR scans, DR scans, TAP reset and idle clocking. Debug firmware and test benches use it to issue HALT/STEP/RESUME/IDCODE/boundary-scan instructions without bit-banging.

## Interface
- `TCK_DIV`, default 4: TCK half-period in `sys_clk` cycles; must be ≥1.
- `MAX_LEN`, default 32: maximum scan length in bits.
- `LW`, default `$clog2(MAX_LEN+1)`: width of `cmd_len`.

One clock, `sys_clk`. Reset `dbg_rst` is asynchronous and active-low.
- `sys_clk`  in  1  system clock.
- `dbg_rst`  in  1  async active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  block idle and able to accept a command.
- `cmd_op`  in  2  operation: 00 RESET, 01 IR scan, 10 DR scan, 11 IDLE clocks.
- `cmd_len`  in  LW  scan length, or TCK count for IDLE.
- `cmd_data`  in  MAX_LEN  TDI bits, shifted LSB first.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  MAX_LEN  captured TDO; bit i = i-th shifted bit; bits ≥ len are 0.
- `tck`  out  1  JTAG clock.
- `tms`  out  1  JTAG mode select.
- `tdi`  out  1  JTAG data out to target.
- `tdo`  in  1  JTAG data from target.
- `trst`  out  1  active-low TAP reset; present only with `JTAG_DRV_TRST_EN`.

## Operation
- States: IDLE, PRE (TMS preamble), SHIFT, POST (TMS postamble), RESP.
- Command accept: `cmd_valid && cmd_ready`.
  - `cmd_ready` is 1 only in IDLE.
  - Op, len and data are registered on accept.
  - `cmd_len > MAX_LEN` is clamped to MAX_LEN.
- Per-op TMS sequences, one value per TCK period. All ops start and end in Run-Test/Idle.
  - RESET: 1,1,1,1,1,0 (6 TCKs).
  - IR, len n ≥ 1: preamble 1,1,0,0; shift n TCKs with TMS=0, last =1; postamble 1,0. Total n+6 TCKs.
  - DR, len n ≥ 1: preamble 1,0,0; shift as IR; postamble 1,0. Total n+5 TCKs.
  - len 0 scan: Capture exits directly via TMS=1. IR: 1,1,0,1,1,0. DR: 1,0,1,1,0. No shift, `rsp_data`=0.
  - IDLE: len TCKs with TMS=0. len 0 produces zero TCKs and an immediate response.
- TDI carries `cmd_data` LSB first during SHIFT only; otherwise 0.
- TDO is sampled only during SHIFT TCKs.
- Every op produces exactly one response. `rsp_data` is 0 for RESET and IDLE.
- RESP: `rsp_valid`=1 and `rsp_data` are held stable until `rsp_ready`; then return to IDLE.
- Outputs on `dbg_rst`: `tck`=0, `tms`=1, `tdi`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0.
  - The block does not auto-reset the TAP. The host issues RESET first.
- Reset mid-operation: immediate abort, outputs return to reset values, and no response is produced. TAP state is then undefined until a RESET op.

## Timing
- TCK period = 2·TCK_DIV `sys_clk` cycles. Low phase first, then high phase.
- `tms`/`tdi` are registered and change only on the first cycle of a low phase, giving setup of TCK_DIV cycles before the rising edge.
- `tdo` is registered on the last `sys_clk` cycle of the high phase, i.e. just before TCK falls.
- First low phase begins the cycle after accept.
- `rsp_valid` rises N·2·TCK_DIV+1 cycles after the accept cycle, where N = TCK count of the op.
- `tck` is held 0 in IDLE and RESP.
- Back-to-back commands: minimum one IDLE cycle between `rsp_ready` handshake and the next accept.

## Configuration
- `JTAG_DRV_TRST_EN` defined:
  - `trst` port exists.
  - Reset value 0; driven to 1 from the first `sys_clk` edge after `dbg_rst` release.
  - RESET op drives `trst`=0 during its five TMS=1 TCKs, then 1 before the final TMS=0 TCK.
- Not defined: no `trst` port; RESET relies on TMS only. All other behaviour is identical.

## Test plan
- TCK_DIV=2, RESET op → 6 TCK pulses, TMS 1,1,1,1,1,0; `rsp_valid` at accept+25; `rsp_data`=0; `trst` low for the first 5 TCKs when enabled.
- IR scan, len 4, data 4'b0001, TDO tied to TDI → TMS 1,1,0,0,0,0,0,1,1,0; TDI during shift 1,0,0,0; `rsp_data`=4'b0001.
- DR scan, len 32, data 32'hDEADBEEF, TDO looped to TDI → 37 TCKs; `rsp_data`=32'hDEADBEEF.
- DR scan len 0 → TMS 1,0,1,1,0; 5 TCKs; `rsp_data`=0. IDLE len 0 → no TCK; `rsp_valid` the cycle after accept.
- `rsp_ready` held low for 10 cycles after `rsp_valid` → `rsp_valid`/`rsp_data` stable, `cmd_ready`=0, `tck`=0 throughout.
- `dbg_rst` asserted during bit 10 of a 32-bit DR shift → outputs at reset values asynchronously; no `rsp_valid`; a following RESET op completes normally.
